// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam logic [31:0] REG_TXDATA = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with free-running wrapping pointers and an occupancy count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [7:0]                 wdata_i,
  input  logic                       pop_i,
  output logic [7:0]                 rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// Bus-attached UART transmitter: TXDATA/STATUS decode, TX FIFO, and an 8N1 shift FSM
// whose line output is always taken from a flop.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_w_enable,
  input  logic        mem_r_enable,
  output logic [31:0] mem_rdata,
  output logic        sel_hit,
  output logic        txd,
  output logic        tx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned TW           = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TimerLoad  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FifoCap    = CW'(FIFO_DEPTH);
  localparam logic [29:0] TxdataWord   = 30'((BASE_ADDR + REG_TXDATA) >> 2);
  localparam logic [29:0] StatusWord   = 30'((BASE_ADDR + REG_STATUS) >> 2);

  logic          hit_tx, hit_st, wr_tx, wr_st, rd_hit;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          overflow_q, sel_hit_q;
  logic [31:0]   rdata_q;

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic          txd_q, txd_d;

  logic unused_bits;
  assign unused_bits = ^{mem_wdata[31:8], mem_addr[1:0]};

  assign hit_tx = (mem_addr[31:2] == TxdataWord);
  assign hit_st = (mem_addr[31:2] == StatusWord);
  assign wr_tx  = mem_w_enable & hit_tx;
  assign wr_st  = mem_w_enable & hit_st;
  // A simultaneous write takes priority, so the read is squashed.
  assign rd_hit = mem_r_enable & ~mem_w_enable & (hit_tx | hit_st);

  // A full FIFO still accepts when the FSM pops in the same cycle.
  assign fifo_push = wr_tx & ((fifo_count < FifoCap) | fifo_pop);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (fifo_push),
    .wdata_i (mem_wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = tx_busy;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVF]   = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      sel_hit_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (wr_tx && !fifo_push) begin
        overflow_q <= 1'b1;
      end else if (wr_st && mem_wdata[ST_OVF]) begin
        overflow_q <= 1'b0;
      end
      sel_hit_q <= rd_hit;
      rdata_q   <= (rd_hit && hit_st) ? status : '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          timer_d  = TimerLoad;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (timer_q == '0) begin
          timer_d = TimerLoad;
          bit_d   = '0;
          state_d = StData;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StData: begin
        if (timer_q == '0) begin
          timer_d = TimerLoad;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StStop: begin
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: the line level is computed from the next state so the flop lines up with it.
  always_comb begin
    txd_d   = 1'b1;
    tx_busy = (state_q != StIdle);
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign mem_rdata = rdata_q;
  assign sel_hit   = sel_hit_q;
  assign txd       = txd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench: table-driven decode checks, directed frame sequences and a randomized
// run against a queue-based transmitter model, with a line-sampling UART receiver scoreboard.
module tb_uart_tx_mmio;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned DEPTH    = 4;
  localparam int          CPB      = 10;
  localparam int          FRAME    = 10 * CPB;    // start + 8 data + stop
  localparam int          POP_GAP  = FRAME + 1;   // one idle-high cycle between frames
  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam logic [31:0] STAT_A   = BASE + 32'h4;
  localparam logic [29:0] TX_W     = BASE >> 2;
  localparam logic [29:0] ST_W     = STAT_A >> 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_w_enable, mem_r_enable, sel_hit, txd, tx_busy;

  uart_tx_mmio #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_w_enable (mem_w_enable),
    .mem_r_enable (mem_r_enable),
    .mem_rdata    (mem_rdata),
    .sel_hit      (sel_hit),
    .txd          (txd),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: FIFO contents as a queue, line occupancy as frame start/end cycles.
  logic [7:0]  m_fifo[$];
  logic [7:0]  exp_bytes[$];
  int          exp_start[$];
  int          line_free = 0;
  int          last_pop  = -1000;
  logic        m_ovf     = 1'b0;
  logic [31:0] exp_rd;
  logic        exp_hit;

  function automatic logic m_busy(input int c);
    return (c > last_pop) && (c < line_free);
  endfunction

  task automatic model_cycle(input logic we, input logic re, input logic [31:0] a,
                             input logic [31:0] wd);
    int   c;
    logic is_tx, is_st;
    c       = cyc;
    is_tx   = (a[31:2] == TX_W);
    is_st   = (a[31:2] == ST_W);
    exp_hit = 1'b0;
    exp_rd  = '0;
    if (reset) begin
      if (m_busy(c) && exp_bytes.size() > 0) begin
        void'(exp_bytes.pop_back());
        void'(exp_start.pop_back());
      end
      m_fifo.delete();
      m_ovf     = 1'b0;
      line_free = 0;
      last_pop  = -1000;
      return;
    end
    if (re && !we && (is_tx || is_st)) begin
      exp_hit = 1'b1;
      if (is_st) exp_rd = {28'b0, m_ovf, m_fifo.size() == 0, m_fifo.size() == DEPTH, m_busy(c)};
    end
    if (m_fifo.size() > 0 && c >= line_free) begin
      exp_bytes.push_back(m_fifo.pop_front());
      exp_start.push_back(c + 1);
      last_pop  = c;
      line_free = c + POP_GAP;
    end
    if (we && is_tx) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(wd[7:0]);
      else m_ovf = 1'b1;
    end
    if (we && is_st && wd[3]) m_ovf = 1'b0;
  endtask

  // Receiver scoreboard: samples the line at mid-bit after each falling start edge.
  logic [7:0] rx_bytes[$];
  int         rx_start[$];
  logic       rx_abort = 1'b0;

  initial begin
    logic [7:0] b;
    int         s;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && txd === 1'b0) begin
        s        = cyc;
        rx_abort = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (!rx_abort) begin
          check("rx_stop_bit", txd, 1);
          rx_bytes.push_back(b);
          rx_start.push_back(s);
        end
      end
    end
  end

  task automatic step(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic hit);
    mem_w_enable = we;
    mem_r_enable = re;
    mem_addr     = a;
    mem_wdata    = wd;
    model_cycle(we, re, a, wd);
    @(posedge clk);
    #1;
    rd           = mem_rdata;
    hit          = sel_hit;
    mem_w_enable = 1'b0;
    mem_r_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [31:0] r;
    logic        h;
    repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, r, h);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        h;
    step(1'b1, 1'b0, a, d, r, h);
  endtask

  task automatic rd_status(input string name, output logic [31:0] r);
    logic h;
    step(1'b0, 1'b1, STAT_A, 32'h0, r, h);
    check({name, "_model_rd"}, r, exp_rd);
    check({name, "_hit"}, h, exp_hit);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    rx_abort = 1'b1;
    idle(n);
    reset    = 1'b0;
  endtask

  task automatic compare_rx(input string name);
    int budget = 0;
    int n;
    while ((m_fifo.size() != 0 || cyc < line_free + CPB) && budget < 5000) begin
      idle(1);
      budget++;
    end
    check({name, "_drain_in_time"}, budget < 5000, 1);
    check({name, "_frame_count"}, rx_bytes.size(), exp_bytes.size());
    n = (rx_bytes.size() < exp_bytes.size()) ? rx_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", name, i), rx_bytes[i], exp_bytes[i]);
      check($sformatf("%s_start%0d", name, i), rx_start[i], exp_start[i]);
    end
    rx_bytes.delete();
    rx_start.delete();
    exp_bytes.delete();
    exp_start.delete();
  endtask

  // Line level k cycles after the store cycle, from the frame format alone.
  function automatic logic line_at(input int k, input logic [7:0] b);
    if (k < 2) return 1'b1;
    if (k < 2 + CPB) return 1'b0;
    if (k < 2 + 9 * CPB) return b[(k - 2 - CPB) / CPB];
    return 1'b1;
  endfunction

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  initial begin
    vec_t        vecs[9];
    logic [31:0] r;
    logic        h;
    logic [7:0]  b;
    int          w, low_cnt, pick;

    vecs[0] = '{1'b0, 1'b1, STAT_A,        32'h0,  32'h4, 1'b1};
    vecs[1] = '{1'b0, 1'b1, BASE,          32'h0,  32'h0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, BASE + 32'h8,  32'h0,  32'h0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, BASE + 32'h6,  32'h0,  32'h4, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'h2000_0004, 32'h0,  32'h0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h2000_0000, 32'h99, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, STAT_A,        32'h0,  32'h4, 1'b1};
    vecs[7] = '{1'b1, 1'b0, STAT_A,        32'h8,  32'h0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, STAT_A,        32'h0,  32'h4, 1'b1};

    mem_addr     = '0;
    mem_wdata    = '0;
    mem_w_enable = 1'b0;
    mem_r_enable = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    do_reset(3);

    check("reset_txd", txd, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_rdata", mem_rdata, 0);
    check("reset_sel_hit", sel_hit, 0);

    // Decode and read-path table.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, r, h);
      if (vecs[i].re) begin
        check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
        check($sformatf("vec%0d_sel_hit", i), h, vecs[i].exp_hit);
      end
    end
    idle(3);

    // Single frame, cycle-exact line shape and busy window.
    b = 8'h55;
    w = cyc;
    wr(BASE, {24'h0, b});
    for (int k = 1; k <= 105; k++) begin
      check($sformatf("t1_txd_k%0d", k), txd, line_at(cyc - w, b));
      if (k == 101) check("t1_busy_last", tx_busy, 1);
      if (k == 102) check("t1_busy_done", tx_busy, 0);
      idle(1);
    end
    compare_rx("t1");

    // Back-to-back frames.
    wr(BASE, 32'hA5);
    wr(BASE, 32'h3C);
    idle(2 * POP_GAP + 10);
    if (rx_bytes.size() == 2) begin
      check("t2_byte0", rx_bytes[0], 32'hA5);
      check("t2_byte1", rx_bytes[1], 32'h3C);
      check("t2_start_gap", rx_start[1] - rx_start[0], POP_GAP);
    end else begin
      check("t2_two_frames", rx_bytes.size(), 2);
    end
    compare_rx("t2");

    // Overflow while a frame is on the line, then clear.
    wr(BASE, 32'h11);
    idle(5);
    for (int i = 0; i < 5; i++) wr(BASE, 32'h21 + i);
    rd_status("t3_ovf", r);
    check("t3_status_ovf", r, 32'hB);
    wr(STAT_A, 32'h8);
    rd_status("t3_clr", r);
    check("t3_status_clr", r, 32'h3);
    compare_rx("t3");

    // Store into a full FIFO in the very cycle the FSM pops.
    wr(BASE, 32'h31);
    idle(3);
    for (int i = 0; i < 4; i++) wr(BASE, 32'h41 + i);
    rd_status("t4_full", r);
    check("t4_status_full", r, 32'h3);
    while (cyc < line_free) idle(1);
    wr(BASE, 32'h45);
    rd_status("t4_after", r);
    check("t4_status_no_ovf", r, 32'h3);
    compare_rx("t4");

    // Reset in the middle of data bit 3.
    wr(BASE, 32'h66);
    wr(BASE, 32'h77);
    while (cyc < last_pop + 1 + CPB + 3 * CPB + CPB / 2) idle(1);
    check("t5_bit3_before_reset", txd, 0);
    do_reset(1);
    check("t5_txd_after_reset", txd, 1);
    rd_status("t5_status", r);
    check("t5_status_empty", r, 32'h4);
    low_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (txd !== 1'b1) low_cnt++;
      idle(1);
    end
    check("t5_line_stays_idle", low_cnt, 0);
    compare_rx("t5");

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      check("rand_busy", tx_busy, m_busy(cyc));
      pick = $urandom_range(0, 99);
      if (pick < 3) begin
        wr(BASE, $urandom);
      end else if (pick < 6) begin
        rd_status("rand_status", r);
      end else if (pick < 7) begin
        wr(STAT_A, $urandom);
      end else if (pick < 8) begin
        step(1'b0, 1'b1, BASE, 32'h0, r, h);
        check("rand_txdata_rd", r, exp_rd);
        check("rand_txdata_hit", h, exp_hit);
      end else if (pick < 9) begin
        step(1'b0, 1'b1, BASE + 32'h10, 32'h0, r, h);
        check("rand_other_hit", h, exp_hit);
      end else begin
        idle(1);
      end
    end
    compare_rx("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog expired at cycle %0d (checks %0d errors %0d)", cyc, checks, errors);
    $fatal(1);
  end

endmodule
